addr_reg_write_arbiter: RTL and testbench
=========================================

Name: addr_reg_write_arbiter

Overview:
- Shares the single write port of the address-register bank (RA, RB, R0) among N_REQ requesters, e.g. fetch, ALU writeback and load unit.
- Drives the 2-bit select that feeds the 2-to-4 address-register decoder, plus the write data and a one-cycle write strobe.
- Arbitration is round-robin. Each write is sequenced as a select-setup cycle followed by a strobe cycle, so the decoder output is stable before the strobe.

Parameters:
- N_REQ, 3, number of requesters (2..4).
- DATA_W, 8, width of the address value written.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  N_REQ  requester i has a pending write.
- req_target  input  2*N_REQ  target select per requester, bits [2i+1:2i]. Encoding: 00=RA, 01=RB, 10=R0, 11=NOP.
- req_data  input  DATA_W*N_REQ  write value per requester, bits [DATA_W*i +: DATA_W].
- req_ready  output  N_REQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
- sel  output  2  select to the decoder; registered.
- wr_data  output  DATA_W  value to the address registers; registered.
- wr_en  output  1  write strobe; registered; high for exactly one cycle per real write.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values, taking effect at the rst edge:
  - state=IDLE, sel=2'b11 (NOP), wr_data=0, wr_en=0, req_ready=0, busy=0.
  - Round-robin pointer ptr=0.
- Reset mid-operation: any in-flight write is abandoned. No wr_en pulse follows the reset edge.
- FSM states: IDLE, SETUP, WRITE.
- IDLE:
  - req_ready is combinational: one-hot for the first valid requester found searching from ptr upward, wrapping modulo N_REQ. It is 0 if no requester is valid. req_ready is 0 in every other state.
  - On a transfer with target != 11:
    - Capture sel<=target and wr_data<=data.
    - ptr<=(grant+1) mod N_REQ.
    - Go to SETUP.
  - On a transfer with target == 11 (NOP):
    - The request is consumed and ptr advances.
    - sel, wr_data and state are unchanged; no wr_en.
  - With no valid requester: stay in IDLE with sel=11.
- SETUP: sel and wr_data held, wr_en=0. Next cycle: WRITE, with wr_en driven to 1 at that edge.
- WRITE:
  - wr_en=1 for this cycle only; sel and wr_data held.
  - Next edge: wr_en<=0, sel<=11, state<=IDLE.
- Timing and throughput:
  - Latency: transfer at edge T, sel valid after T, wr_en high during cycle T+1..T+2.
  - Throughput: one real write per 3 cycles; a NOP consumes one IDLE cycle.
- Fairness: no requester waits more than N_REQ grants. A requester that stays valid is not re-granted until every other valid requester has been served.
- Requester contract: req_target and req_data are sampled only at the transfer edge. They may change freely while req_ready=0.
- Grant stability: req_valid deasserting without a transfer is legal; the grant simply moves.
- Simultaneous requests targeting the same register are serialized in round-robin order, so the later write wins.

Optional Feature:
- Macro: ADDR_ARB_PRIO0_EN.
- Defined: requester 0 wins in IDLE whenever req_valid[0]=1, regardless of ptr. The remaining requesters are round-robin among themselves. ptr is updated only on grants to requesters 1..N_REQ-1.
- Undefined: pure round-robin as described above.

Decomposition:
- Package addr_arb_pkg:
  - Select constants SEL_RA=2'b00, SEL_RB=2'b01, SEL_R0=2'b10, SEL_NOP=2'b11.
  - FSM enum arb_state_t {IDLE, SETUP, WRITE}.
- Sub-module rr_pick:
  - Combinational round-robin picker.
  - Inputs: valid vector and ptr. Outputs: one-hot grant and its index.
  - Keeps the FSM module free of search logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all req_valid=0 -> sel=11, wr_en=0, req_ready=0, busy=0 for 10 cycles.
- Single write: req0 target=01, data=8'h3C -> req_ready=001 same cycle; next cycle sel=01, wr_data=3C; wr_en=1 exactly one cycle later; back in IDLE with sel=11.
- Round-robin: all three valid continuously with targets 00/01/10 and data A0/B1/C2 -> grant order 0,1,2,0,…; wr_en pulses every 3 cycles carrying A0, B1, C2 in turn.
- NOP: req1 target=11, data=FF -> req_ready=010 for one cycle, no wr_en, ptr advances. Then req1 and req2 both valid -> req2 is granted first.
- Reset mid-write: rst asserted during SETUP of data 55 -> no wr_en pulse at all; outputs return to reset values the next cycle.
- Priority option (macro defined): req0 held valid with req1 and req2 valid -> req0 granted every IDLE cycle. Undefined build: order 0,1,2.

Source files
------------

// File: rtl/addr_arb_pkg.sv
// rtl/addr_arb_pkg.sv - shared select encodings and FSM state type for the address-register write arbiter
package addr_arb_pkg;

    localparam logic [1:0] SEL_RA  = 2'b00;
    localparam logic [1:0] SEL_RB  = 2'b01;
    localparam logic [1:0] SEL_R0  = 2'b10;
    localparam logic [1:0] SEL_NOP = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first valid requester at or above ptr, wrapping
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [PTR_W:0]     sum;

    // Rotate the valid vector so ptr sits at bit 0, take the lowest set bit, then rotate the index back
    always_comb begin
        dbl       = {valid, valid} >> ptr;
        rot       = dbl[N_REQ-1:0];
        grant_any = |rot;
        sum       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = (PTR_W+1)'(k);
            end
        end
        sum = sum + {1'b0, ptr};
        if (sum >= (PTR_W+1)'(N_REQ)) begin
            sum = sum - (PTR_W+1)'(N_REQ);
        end
        grant_idx = sum[PTR_W-1:0];
        grant     = grant_any ? (N_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/addr_reg_write_arbiter.sv
// rtl/addr_reg_write_arbiter.sv - round-robin arbiter for the RA/RB/R0 write port; ADDR_ARB_PRIO0_EN gives requester 0 fixed priority
module addr_reg_write_arbiter
    import addr_arb_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [2*N_REQ-1:0]      req_target,
    input  logic [DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [1:0]              sel,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    wr_en,
    output logic                    busy
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_t        state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    logic [N_REQ-1:0]  pick_valid;
    logic [N_REQ-1:0]  rr_grant;
    logic [PTR_W-1:0]  rr_idx;
    logic              rr_any;

    logic [N_REQ-1:0]  arb_grant;
    logic [PTR_W-1:0]  arb_idx;
    logic              arb_any;
    logic              ptr_adv;
    logic [1:0]        g_target;
    logic [DATA_W-1:0] g_data;
    logic [PTR_W-1:0]  ptr_next;

`ifdef ADDR_ARB_PRIO0_EN
    assign pick_valid = req_valid & {{(N_REQ-1){1'b1}}, 1'b0};
`else
    assign pick_valid = req_valid;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .valid     (pick_valid),
        .ptr       (ptr_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .grant_any (rr_any)
    );

    // Final grant: requester 0 may pre-empt the rotation; only rotation grants move the pointer
    always_comb begin
        arb_grant = rr_grant;
        arb_idx   = rr_idx;
        arb_any   = rr_any;
        ptr_adv   = rr_any;
`ifdef ADDR_ARB_PRIO0_EN
        if (req_valid[0]) begin
            arb_grant = N_REQ'(1);
            arb_idx   = '0;
            arb_any   = 1'b1;
            ptr_adv   = 1'b0;
        end
`endif
    end

    // Mux out the granted requester's target and data
    always_comb begin
        g_target = SEL_NOP;
        g_data   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
                g_target = req_target[2*i +: 2];
                g_data   = req_data[DATA_W*i +: DATA_W];
            end
        end
        ptr_next = (arb_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end

    assign req_ready = (state_q == IDLE && !rst) ? arb_grant : '0;
    assign sel       = sel_q;
    assign wr_data   = wr_data_q;
    assign wr_en     = wr_en_q;
    assign busy      = (state_q != IDLE);

    // Next-state: IDLE grants, SETUP lets the decoder settle, WRITE carries the single strobe
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    if (ptr_adv) begin
                        ptr_d = ptr_next;
                    end
                    if (g_target != SEL_NOP) begin
                        sel_d     = g_target;
                        wr_data_d = g_data;
                        state_d   = SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = WRITE;
                wr_en_d = 1'b1;
            end
            WRITE: begin
                state_d = IDLE;
                sel_d   = SEL_NOP;
            end
            default: begin
                state_d = IDLE;
                sel_d   = SEL_NOP;
            end
        endcase
    end

    // State register; reset abandons any write in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= SEL_NOP;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            ptr_q     <= ptr_d;
        end
    end

endmodule

// File: tb/tb_addr_reg_write_arbiter.sv
// tb/tb_addr_reg_write_arbiter.sv - scoreboard bench for addr_reg_write_arbiter
module tb_addr_reg_write_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [5:0]  req_target;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic [1:0]  sel;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [9:0] exp_q[$];
    int         grant_log[$];
    int         wr_cyc[$];

    addr_reg_write_arbiter #(
        .N_REQ  (3),
        .DATA_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_target (req_target),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .sel        (sel),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] t, input logic [7:0] d);
        req_valid[i]      = v;
        req_target[2*i+:2] = t;
        req_data[8*i+:8]   = d;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        grant_log.delete();
        wr_cyc.delete();
    endtask

    task automatic wait_grants(input string tag, input int n, input int budget);
        int k = 0;
        while (grant_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, grant_log.size() >= n, 1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: record transfers offered by the bench, compare each strobe against them
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst) begin
            if (wr_en) begin
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_sel", sel, e[9:8]);
                    chk("wr_data", wr_data, e[7:0]);
                end
            end
            if (req_ready != 0) begin
                chk("ready_onehot", $countones(req_ready), 1);
            end
            for (int i = 0; i < 3; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    grant_log.push_back(i);
                    if (req_target[2*i+:2] != 2'b11) begin
                        exp_q.push_back({req_target[2*i+:2], req_data[8*i+:8]});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr[6];
`ifdef ADDR_ARB_PRIO0_EN
        exp_rr = '{0, 0, 0, 0, 0, 0};
`else
        exp_rr = '{0, 1, 2, 0, 1, 2};
`endif
        rst        = 1'b1;
        req_valid  = '0;
        req_target = '0;
        req_data   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset then idle
        repeat (10) begin
            @(negedge clk);
            chk("idle_sel", sel, 2'b11);
            chk("idle_wr_en", wr_en, 0);
            chk("idle_ready", req_ready, 0);
            chk("idle_busy", busy, 0);
            chk("idle_wr_data", wr_data, 0);
        end

        // single write with exact timing
        @(posedge clk); #1;
        set_req(0, 1'b1, 2'b01, 8'h3C);
        @(negedge clk);
        chk("single_ready", req_ready, 3'b001);
        chk("single_busy0", busy, 0);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("setup_sel", sel, 2'b01);
        chk("setup_data", wr_data, 8'h3C);
        chk("setup_wr_en", wr_en, 0);
        chk("setup_busy", busy, 1);
        chk("setup_ready", req_ready, 0);
        @(negedge clk);
        chk("write_wr_en", wr_en, 1);
        chk("write_sel", sel, 2'b01);
        chk("write_busy", busy, 1);
        @(negedge clk);
        chk("after_wr_en", wr_en, 0);
        chk("after_sel", sel, 2'b11);
        chk("after_busy", busy, 0);
        wait_drain("single_drain", 5);

        // round-robin with all three requesters held valid
        do_reset();
        set_req(0, 1'b1, 2'b00, 8'hA0);
        set_req(1, 1'b1, 2'b01, 8'hB1);
        set_req(2, 1'b1, 2'b10, 8'hC2);
        wait_grants("rr_grants", 6, 40);
        @(posedge clk); #1;
        req_valid = '0;
        wait_drain("rr_drain", 10);
        chk("rr_nwrites", wr_cyc.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < grant_log.size()) chk($sformatf("rr_order%0d", k), grant_log[k], exp_rr[k]);
        end
        for (int k = 0; k + 1 < wr_cyc.size(); k++) begin
            chk($sformatf("rr_spacing%0d", k), wr_cyc[k+1] - wr_cyc[k], 3);
        end

        // NOP consumes a grant, advances ptr, no strobe
        do_reset();
        set_req(1, 1'b1, 2'b11, 8'hFF);
        @(negedge clk);
        chk("nop_ready", req_ready, 3'b010);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("nop_busy", busy, 0);
        chk("nop_sel", sel, 2'b11);
        chk("nop_wr_en", wr_en, 0);
        @(posedge clk); #1;
        set_req(1, 1'b1, 2'b00, 8'h11);
        set_req(2, 1'b1, 2'b10, 8'h22);
        @(negedge clk);
        chk("nop_next_ready", req_ready, 3'b100);
        wait_grants("nop_grants", 3, 20);
        @(posedge clk); #1;
        req_valid = '0;
        wait_drain("nop_drain", 10);
        if (grant_log.size() >= 3) begin
            chk("nop_order0", grant_log[0], 1);
            chk("nop_order1", grant_log[1], 2);
            chk("nop_order2", grant_log[2], 1);
        end
        chk("nop_nwrites", wr_cyc.size(), 2);

        // reset during SETUP abandons the write
        do_reset();
        set_req(0, 1'b1, 2'b10, 8'h55);
        @(negedge clk);
        chk("rst_mid_ready", req_ready, 3'b001);
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_sel", sel, 2'b11);
        chk("rst_mid_data", wr_data, 0);
        chk("rst_mid_wr_en", wr_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready0", req_ready, 0);
        repeat (5) @(negedge clk);
        chk("rst_mid_nwrites", wr_cyc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
